// File: rtl/pwm_fader_if.sv
// rtl/pwm_fader_if.sv - control and output bundle between the fader and its driver
interface pwm_fader_if #(
    parameter int N          = 8,
    parameter int PRESCALE_W = 16,
    parameter int HOLD_W     = 8
);
    logic                  ena;
    logic [PRESCALE_W-1:0] prescale;
    logic [N-1:0]          step_size;
    logic [HOLD_W-1:0]     hold;
    logic                  step;
    logic                  period_start;
    logic [N-1:0]          duty;
    logic [1:0]            phase;

    modport master (
        output ena, prescale, step_size, hold,
        input  step, period_start, duty, phase
    );

    modport slave (
        input  ena, prescale, step_size, hold,
        output step, period_start, duty, phase
    );
endinterface

// File: rtl/pwm_fader.sv
// rtl/pwm_fader.sv - breathing duty generator with step prescaler; PWM_FADER_GAMMA_EN adds a perceptual duty curve
module pwm_fader #(
    parameter int N          = 8,
    parameter int PRESCALE_W = 16,
    parameter int HOLD_W     = 8
) (
    input  logic       clk,
    input  logic       rst,
    pwm_fader_if.slave bus
);
    localparam logic [N-1:0] L_MAX = {N{1'b1}};

    typedef enum logic [1:0] {
        S_LOW  = 2'd0,
        S_UP   = 2'd1,
        S_HIGH = 2'd2,
        S_DOWN = 2'd3
    } state_t;

    logic [PRESCALE_W-1:0] r_pc;
    logic                  r_step;
    logic                  r_pstart;
    logic [N-1:0]          r_pcnt;
    logic [HOLD_W-1:0]     r_hc;
    state_t                r_state;
    logic [N-1:0]          r_lin;

    logic                  w_wrap;
    logic [N-1:0]          w_pcnt_next;
    logic                  w_adv;
    logic [N-1:0]          w_s;
    logic [N:0]            w_sum;
    state_t                w_state_next;
    logic [HOLD_W-1:0]     w_hc_next;
    logic [N-1:0]          w_lin_next;

    assign w_wrap      = (r_pc >= bus.prescale);
    // pcnt as it will read during the cycle the next step is presented
    assign w_pcnt_next = r_step ? (r_pcnt + 1'b1) : r_pcnt;
    assign w_adv       = bus.ena && r_pstart;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc     <= '0;
            r_step   <= 1'b0;
            r_pstart <= 1'b0;
            r_pcnt   <= '0;
        end else if (bus.ena) begin
            r_pc     <= w_wrap ? '0 : (r_pc + 1'b1);
            r_step   <= w_wrap;
            r_pstart <= w_wrap && (w_pcnt_next == L_MAX);
            r_pcnt   <= w_pcnt_next;
        end else begin
            r_step   <= 1'b0;
            r_pstart <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_LOW;
            r_hc    <= '0;
            r_lin   <= '0;
        end else if (w_adv) begin
            r_state <= w_state_next;
            r_hc    <= w_hc_next;
            r_lin   <= w_lin_next;
        end
    end

    assign w_s   = (bus.step_size == '0) ? {{(N-1){1'b0}}, 1'b1} : bus.step_size;
    assign w_sum = {1'b0, r_lin} + {1'b0, w_s};

    always_comb begin
        w_state_next = r_state;
        w_hc_next    = r_hc;
        w_lin_next   = r_lin;
        case (r_state)
            S_LOW: begin
                w_lin_next = '0;
                // equality exit: a hold lowered below hc runs hc through the wrap
                if (r_hc == bus.hold) begin
                    w_hc_next    = '0;
                    w_state_next = S_UP;
                end else begin
                    w_hc_next = r_hc + 1'b1;
                end
            end
            S_UP: begin
                if (w_sum >= {1'b0, L_MAX}) begin
                    w_lin_next   = L_MAX;
                    w_state_next = S_HIGH;
                end else begin
                    w_lin_next = w_sum[N-1:0];
                end
            end
            S_HIGH: begin
                w_lin_next = L_MAX;
                if (r_hc == bus.hold) begin
                    w_hc_next    = '0;
                    w_state_next = S_DOWN;
                end else begin
                    w_hc_next = r_hc + 1'b1;
                end
            end
            S_DOWN: begin
                if (r_lin <= w_s) begin
                    w_lin_next   = '0;
                    w_state_next = S_LOW;
                end else begin
                    w_lin_next = r_lin - w_s;
                end
            end
            default: begin
                w_state_next = S_LOW;
                w_lin_next   = '0;
                w_hc_next    = '0;
            end
        endcase
    end

    assign bus.step         = r_step;
    assign bus.period_start = r_pstart;
    assign bus.phase        = r_state;

`ifdef PWM_FADER_GAMMA_EN
    logic [2*N-1:0] w_gprod;
    logic [N-1:0]   r_duty;

    // (L+1)*L >> N keeps both endpoints exact: 0 -> 0 and MAX -> MAX
    assign w_gprod = ({{N{1'b0}}, r_lin} + {{(2*N-1){1'b0}}, 1'b1}) * {{N{1'b0}}, r_lin};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_duty <= '0;
        end else begin
            r_duty <= w_gprod[2*N-1:N];
        end
    end

    assign bus.duty = r_duty;
`else
    assign bus.duty = r_lin;
`endif
endmodule

// File: tb/tb_pwm_fader.sv
// tb/tb_pwm_fader.sv - directed self-checking bench for pwm_fader (N=4)
module tb_pwm_fader;
    localparam int N  = 4;
    localparam int PW = 16;
    localparam int HW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pwm_fader_if #(.N(N), .PRESCALE_W(PW), .HOLD_W(HW)) bus ();

    pwm_fader #(.N(N), .PRESCALE_W(PW), .HOLD_W(HW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    task automatic wait_pstart(input string tag, input int budget, output int n_cyc, output int n_step);
        bit found;
        found  = 1'b0;
        n_cyc  = 0;
        n_step = 0;
        while (!found && n_cyc < budget) begin
            tick();
            n_cyc++;
            if (bus.step === 1'b1) n_step++;
            if (bus.period_start === 1'b1) found = 1'b1;
        end
        checks++;
        assert (found) else begin
            errors++;
            $error("FAIL %s period_start timeout got 0 exp 1", tag);
        end
    endtask

    task automatic boundary(input string tag, input int prev_duty, input int exp_duty, input int exp_phase);
        check({tag, "_hold_duty"}, 32'(bus.duty), 32'(prev_duty));
        tick();
        check({tag, "_duty"}, 32'(bus.duty), 32'(exp_duty));
        check({tag, "_phase"}, 32'(bus.phase), 32'(exp_phase));
    endtask

    initial begin
        int nc;
        int ns;
        int g;
        int prev;
        int ed;
        int ep;
        int fd[12] = '{0, 0, 4, 8, 12, 15, 15, 15, 11, 7, 3, 0};
        int fp[12] = '{0, 1, 1, 1, 1, 2, 2, 3, 3, 3, 3, 0};

        rst           = 1'b1;
        bus.ena       = 1'b0;
        bus.prescale  = '0;
        bus.step_size = '0;
        bus.hold      = '0;
        repeat (3) tick();
        check("rst_duty", 32'(bus.duty), 0);
        check("rst_phase", 32'(bus.phase), 0);
        check("rst_step", 32'(bus.step), 0);
        check("rst_pstart", 32'(bus.period_start), 0);

        // prescale=2: step every 3rd clk, first period_start on the 16th step
        bus.prescale  = 16'd2;
        bus.step_size = 4'd4;
        bus.hold      = 8'd1;
        bus.ena       = 1'b1;
        rst           = 1'b0;
        for (int k = 1; k <= 48; k++) begin
            tick();
            check("pre_step", 32'(bus.step), 32'((k % 3) == 0));
            check("pre_pstart", 32'(bus.period_start), 32'(k == 48));
            check("pre_duty", 32'(bus.duty), 0);
        end
        tick();
        check("pre_b1_duty", 32'(bus.duty), 0);
        check("pre_b1_phase", 32'(bus.phase), 0);

        // full fade, prescale=0, step_size=4, hold=1
        bus.prescale  = 16'd0;
        bus.step_size = 4'd4;
        bus.hold      = 8'd1;
        do_reset();
        prev = 0;
        for (int b = 0; b < 12; b++) begin
            wait_pstart("fade", 100, nc, ns);
            check("fade_gap", 32'(nc), (b == 0) ? 32'd16 : 32'd15);
            boundary("fade", prev, fd[b], fp[b]);
            prev = fd[b];
        end

        // step_size=0 acts as 1, hold=0 leaves LOW/HIGH at the first boundary
        bus.step_size = 4'd0;
        bus.hold      = 8'd0;
        do_reset();
        prev = 0;
        for (int b = 1; b <= 18; b++) begin
            ed = (b == 1) ? 0 : (b <= 15) ? b - 1 : (b <= 17) ? 15 : 14;
            ep = (b <= 15) ? 1 : (b == 16) ? 2 : 3;
            wait_pstart("edge", 100, nc, ns);
            boundary("edge", prev, ed, ep);
            prev = ed;
        end

        // freeze mid-UP
        bus.prescale  = 16'd2;
        bus.step_size = 4'd4;
        bus.hold      = 8'd0;
        do_reset();
        wait_pstart("frz_b1", 200, nc, ns);
        boundary("frz_b1", 0, 0, 1);
        wait_pstart("frz_b2", 200, nc, ns);
        boundary("frz_b2", 0, 4, 1);
        ns = 0;
        g  = 0;
        while (ns < 5 && g < 100) begin
            tick();
            g++;
            if (bus.step === 1'b1) ns++;
        end
        while (bus.step === 1'b1 && g < 100) begin
            tick();
            g++;
        end
        bus.ena = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            check("frz_step", 32'(bus.step), 0);
            check("frz_pstart", 32'(bus.period_start), 0);
            check("frz_duty", 32'(bus.duty), 4);
            check("frz_phase", 32'(bus.phase), 1);
        end
        bus.ena = 1'b1;
        wait_pstart("frz_resume", 200, nc, ns);
        check("frz_steps_left", 32'(ns), 11);
        tick();
        check("frz_after_duty", 32'(bus.duty), 8);
        check("frz_after_phase", 32'(bus.phase), 1);

        // reset while HIGH at duty=15
        bus.prescale  = 16'd0;
        bus.step_size = 4'd15;
        bus.hold      = 8'd0;
        do_reset();
        wait_pstart("mid_b1", 100, nc, ns);
        boundary("mid_b1", 0, 0, 1);
        wait_pstart("mid_b2", 100, nc, ns);
        boundary("mid_b2", 0, 15, 2);
        rst          = 1'b1;
        bus.prescale = 16'd2;
        tick();
        check("mid_rst_duty", 32'(bus.duty), 0);
        check("mid_rst_phase", 32'(bus.phase), 0);
        check("mid_rst_step", 32'(bus.step), 0);
        check("mid_rst_pstart", 32'(bus.period_start), 0);
        rst = 1'b0;
        tick();
        check("mid_step_c1", 32'(bus.step), 0);
        tick();
        check("mid_step_c2", 32'(bus.step), 0);
        tick();
        check("mid_step_c3", 32'(bus.step), 1);
        wait_pstart("mid_pcnt", 200, nc, ns);
        check("mid_pcnt_steps", 32'(ns), 15);
        check("mid_pcnt_cycles", 32'(nc), 45);
        tick();
        check("mid_b1_phase", 32'(bus.phase), 1);
        check("mid_b1_duty", 32'(bus.duty), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pwm_fader.md
Name: pwm_fader

Overview:
- Upstream driver for the pwm stage. Generates the slow `step` enable tick and a time-varying `duty` word that ramps up, holds, ramps down and holds, i.e. a "breathing" fade.
- Outputs connect directly to pwm `step`/`duty`. `ena` is shared with pwm.
- Duty changes only at PWM period boundaries, so the downstream comparison never glitches mid-period.

Parameters:
- N, 8, duty width; must equal the downstream pwm N.
- PRESCALE_W, 16, width of the step prescaler.
- HOLD_W, 8, width of the hold-period count.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- ena  in  1  run enable; 0 freezes the block.
- prescale  in  PRESCALE_W  clk cycles per step, minus 1.
- step_size  in  N  duty increment/decrement per period; 0 is treated as 1.
- hold  in  HOLD_W  extra periods to dwell at 0 and at max.
- step  out  1  one-cycle tick to pwm `step`.
- period_start  out  1  one-cycle pulse on the step that wraps the period counter.
- duty  out  N  duty word to pwm `duty`.
- phase  out  2  FSM state: 0=LOW, 1=UP, 2=HIGH, 3=DOWN.

Behaviour:
- Reset values: prescaler pc=0, period counter pcnt=0, hold counter hc=0, state LOW, duty=0, step=0, period_start=0. Reset overrides `ena`.
- Prescaler, when ena=1:
  - If pc >= prescale: pc<=0 and step<=1 on the next cycle.
  - Otherwise pc<=pc+1 and step<=0.
  - The >= compare means a mid-run decrease of `prescale` wraps on the next cycle.
  - prescale=0 gives step high every cycle.
- Period counter: N bits, increments on each registered step and wraps 2^N-1 to 0.
  - period_start is registered and asserted in the same cycle as the step where pcnt==2^N-1 before the increment.
  - This keeps pcnt in lockstep with the pwm internal counter, since both reset together.
- ena=0: step=0, period_start=0, and pc, pcnt, hc, state and duty all hold. On re-enable the block resumes with no lost or extra ticks.
- FSM advances only on clock edges where period_start=1. MAX=2^N-1, s = (step_size==0) ? 1 : step_size.
  - LOW: duty=0. If hc==hold then hc<=0 and go UP, else hc++.
  - UP: if duty+s >= MAX then duty<=MAX and go HIGH, else duty<=duty+s. Compute in N+1 bits; saturate, never wrap.
  - HIGH: duty=MAX. Same hold rule as LOW; exit goes to DOWN.
  - DOWN: if duty <= s then duty<=0 and go LOW, else duty<=duty-s. Saturate at 0.
- Hold timing: hold=h dwells h+1 boundaries; hold=0 leaves at the first boundary.
- Transitions LOW->UP and HIGH->DOWN do not change duty on that edge.
- Latency: a new duty is visible the cycle after the period_start pulse.
- Input sampling:
  - step_size and hold are sampled at the boundary where they are used.
  - A hold change during a dwell takes effect at the next compare.
  - If hold is reduced below hc, the dwell does not end on an equality match. hc keeps incrementing through the HOLD_W wrap and exits when it next equals hold.
- All outputs are registered. No combinational path runs from inputs to outputs.

Optional Feature:
- Macro PWM_FADER_GAMMA_EN.
- Defined: the internal linear duty L passes through a registered perceptual curve, duty = ((L+1)*L) >> N, computed in 2N bits.
  - Endpoints are exact: L=0 gives 0, L=MAX gives MAX.
  - Adds 1 cycle of duty latency; duty resets to 0.
- Undefined: duty = L directly, with no extra register stage.
- phase, step and period_start are identical either way.

Test Plan:
- Reset / prescale: rst held 3 cycles, then N=4, prescale=2, ena=1 -> duty=0, phase=0; step high exactly every 3rd clk; first period_start on the 16th step (clk 48).
- Full fade (N=4, prescale=0, step_size=4, hold=1):
  - LOW dwells 2 boundaries.
  - Duty over successive boundaries: 0, 4, 8, 12, 15 (saturates, enters HIGH).
  - HIGH dwells 2 boundaries.
  - Then 11, 7, 3, 0 (enters LOW).
- Edge inputs (N=4, prescale=0): step_size=0 -> duty increments by 1 per period. hold=0 -> LOW/HIGH last exactly one boundary.
- Freeze: ena dropped for 20 clks mid-UP -> step=0, duty and phase constant. After re-enable, the step count to the next period_start equals the remaining count before the freeze.
- Reset mid-operation: rst asserted in HIGH with duty=15 -> next cycle duty=0, phase=0, pcnt=0, no step for the following prescale+1 cycles.
- Gamma (PWM_FADER_GAMMA_EN, N=8):
  - L=0 -> 0, L=128 -> 64, L=255 -> 255.
  - duty lags the non-gamma build by exactly 1 clk.
